// File: rtl/driver_trace_buffer_reader_if.sv
// Output stream bundle for the trace buffer reader.
//   m_tdata  : stream data word
//   m_tvalid : data word valid
//   m_tready : downstream ready
//   m_tlast  : final word of a transfer
// master = reader side, slave = host DMA/AXI bridge side.
interface driver_trace_buffer_reader_if #(
    parameter int unsigned DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/driver_trace_buffer_reader.sv
// Read-side engine for trace buffer BRAM port B.
// On a start command, reads rd_len consecutive words (wrapping modulo the
// buffer depth) from start_addr and streams them out. BRAM latency and
// downstream backpressure are absorbed by a credit-controlled output FIFO.
// Ports:
//   clk, rstn              : clock, asynchronous active-low reset
//   start, start_addr      : command pulse and first word address
//   rd_len                 : word count, 0..2^TRACE_BUF_ADDR_WIDTH
//   abort                  : cancel the current transfer
//   trace_buf_bram_addrb/enb/doutb : BRAM port B (read only)
//   stream                 : valid/ready output stream (master modport)
//   busy, done             : transfer in progress / completion pulse
module driver_trace_buffer_reader #(
    parameter int unsigned TRACE_BUF_DATA_WIDTH = 256,
    parameter int unsigned TRACE_BUF_ADDR_WIDTH = 15,
    parameter int unsigned BRAM_RD_LATENCY      = 2,
    parameter int unsigned OUT_FIFO_DEPTH       = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [TRACE_BUF_ADDR_WIDTH-1:0] start_addr,
    input  logic [TRACE_BUF_ADDR_WIDTH:0]   rd_len,
    input  logic                            abort,
    output logic [TRACE_BUF_ADDR_WIDTH-1:0] trace_buf_bram_addrb,
    output logic                            trace_buf_bram_enb,
    input  logic [TRACE_BUF_DATA_WIDTH-1:0] trace_buf_bram_doutb,
    driver_trace_buffer_reader_if.master    stream,
    output logic                            busy,
    output logic                            done
);
    localparam int unsigned AW = TRACE_BUF_ADDR_WIDTH;
    localparam int unsigned LW = TRACE_BUF_ADDR_WIDTH + 1;
    localparam int unsigned PW = $clog2(OUT_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_next;

    logic [AW-1:0]                   addr;
    logic [LW-1:0]                   issue_rem;
    logic [LW-1:0]                   beat_rem;
    logic [BRAM_RD_LATENCY-1:0]      rd_pipe;
    logic [TRACE_BUF_DATA_WIDTH-1:0] fifo_mem [OUT_FIFO_DEPTH];
    logic [PW-1:0]                   wr_ptr;
    logic [PW-1:0]                   rd_ptr;
    logic [PW:0]                     fifo_count;
    logic [7:0]                      inflight;
    logic credit_ok, issue, accept, zero_len, fifo_wr;
    logic tvalid, tlast, beat, last_beat;

    assign accept    = (state == IDLE) && start && !abort && (rd_len != '0);
    assign zero_len  = (state == IDLE) && start && !abort && (rd_len == '0);
    assign fifo_wr   = rd_pipe[BRAM_RD_LATENCY-1];
    assign tvalid    = (fifo_count != '0);
    assign tlast     = tvalid && (beat_rem == LW'(1));
    assign beat      = tvalid && stream.m_tready;
    assign last_beat = beat && tlast;

    // A read holds a credit from the moment enb is registered until its data
    // lands in the FIFO, so the enb stage counts alongside the latency pipe.
    always_comb begin
        inflight = 8'(trace_buf_bram_enb);
        for (int unsigned i = 0; i < BRAM_RD_LATENCY; i++) begin
            inflight = inflight + 8'(rd_pipe[i]);
        end
    end

    assign credit_ok = (32'(inflight) + 32'(fifo_count)) < OUT_FIFO_DEPTH;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:  if (accept) state_next = ISSUE;
            ISSUE: begin
                issue = (issue_rem != '0) && credit_ok;
                if (issue && (issue_rem == LW'(1))) state_next = DRAIN;
            end
            DRAIN: if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            issue      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trace_buf_bram_addrb <= '0;
            trace_buf_bram_enb   <= 1'b0;
            addr                 <= '0;
            issue_rem            <= '0;
            beat_rem             <= '0;
            rd_pipe              <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            fifo_count           <= '0;
            done                 <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Clearing the latency pipe discards reads still in the BRAM.
                trace_buf_bram_enb <= 1'b0;
                rd_pipe            <= '0;
                wr_ptr             <= '0;
                rd_ptr             <= '0;
                fifo_count         <= '0;
                issue_rem          <= '0;
                beat_rem           <= '0;
            end else begin
                trace_buf_bram_enb <= issue;
                rd_pipe[0] <= trace_buf_bram_enb;
                for (int unsigned i = 1; i < BRAM_RD_LATENCY; i++) begin
                    rd_pipe[i] <= rd_pipe[i-1];
                end
                if (accept) begin
                    addr      <= start_addr;
                    issue_rem <= rd_len;
                    beat_rem  <= rd_len;
                end
                if (issue) begin
                    trace_buf_bram_addrb <= addr;
                    addr                 <= addr + AW'(1);
                    issue_rem            <= issue_rem - LW'(1);
                end
                if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
                if (beat) begin
                    rd_ptr   <= rd_ptr + PW'(1);
                    beat_rem <= beat_rem - LW'(1);
                end
                fifo_count <= fifo_count + (PW+1)'(fifo_wr) - (PW+1)'(beat);
                done       <= zero_len || last_beat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= trace_buf_bram_doutb;
    end

    assign stream.m_tdata  = tvalid ? fifo_mem[rd_ptr] : '0;
    assign stream.m_tvalid = tvalid;
    assign stream.m_tlast  = tlast;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_driver_trace_buffer_reader.sv
// Self-checking bench for driver_trace_buffer_reader with a 2-cycle BRAM model.
module tb_driver_trace_buffer_reader;
    localparam int unsigned DW = 256;
    localparam int unsigned AW = 15;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] len;
        int          mode;          // 0: ready high, 1: random ready, 2: ready low 30 cycles
        int          stall_issues;  // reads expected during the stall, -1 = unchecked
        int          restart_cyc;   // cycle to pulse a second start while busy, -1 = none
        logic [14:0] last_addr;
    } vec_t;

    typedef struct {
        logic        enb;
        logic [14:0] addrb;
        logic        tvalid;
        logic        tlast;
        logic [14:0] daddr;
        logic        busy;
        logic        done;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [14:0]   start_addr = '0;
    logic [15:0]   rd_len = '0;
    logic [14:0]   addrb;
    logic          enb;
    logic [255:0]  doutb;
    logic          busy;
    logic          done;
    logic [255:0]  bram_pipe [2];
    int            checks = 0;
    int            errors = 0;

    driver_trace_buffer_reader_if #(.DATA_WIDTH(DW)) stream_if();

    driver_trace_buffer_reader #(
        .TRACE_BUF_DATA_WIDTH(DW),
        .TRACE_BUF_ADDR_WIDTH(AW),
        .BRAM_RD_LATENCY(2),
        .OUT_FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .start_addr(start_addr),
        .rd_len(rd_len),
        .abort(abort),
        .trace_buf_bram_addrb(addrb),
        .trace_buf_bram_enb(enb),
        .trace_buf_bram_doutb(doutb),
        .stream(stream_if),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] word(input logic [14:0] a);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = {a, 17'(i)} ^ 32'hC3A5_5A3C;
        return w;
    endfunction

    // BRAM: address sampled on the edge after enb is registered, data valid
    // two edges after the enb edge.
    always @(posedge clk) begin
        bram_pipe[0] <= enb ? word(addrb) : {8{32'hDEAD_BEEF}};
        bram_pipe[1] <= bram_pipe[0];
    end
    assign doutb = bram_pipe[1];

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input vec_t v, input int idx);
        int beats = 0;
        int enbs = 0;
        int dones = 0;
        int cyc = 0;
        int len;
        bit held_v = 1'b0;
        logic [255:0] held_d = '0;
        logic held_l = 1'b0;
        logic [14:0] ea;
        len = int'(v.len);
        start = 1'b1; start_addr = v.addr; rd_len = v.len;
        step();
        start = 1'b0;
        while (beats < len && cyc < 5000) begin
            if (cyc == v.restart_cyc) begin
                start = 1'b1; start_addr = 15'h0400; rd_len = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (cyc == 30 && v.stall_issues >= 0)
                check($sformatf("v%0d_stall_issues", idx), 256'(enbs), 256'(v.stall_issues));
            if (enb) begin
                ea = v.addr + 15'(enbs);
                check($sformatf("v%0d_addrb%0d", idx, enbs), 256'(addrb), 256'(ea));
                enbs++;
            end
            if (done) dones++;
            case (v.mode)
                1:       stream_if.m_tready = 1'($urandom_range(0, 1));
                2:       stream_if.m_tready = (cyc >= 30);
                default: stream_if.m_tready = 1'b1;
            endcase
            if (stream_if.m_tvalid) begin
                if (held_v) begin
                    check($sformatf("v%0d_hold_data", idx), stream_if.m_tdata, held_d);
                    check($sformatf("v%0d_hold_last", idx), 256'(stream_if.m_tlast), 256'(held_l));
                end
                if (stream_if.m_tready) begin
                    ea = v.addr + 15'(beats);
                    check($sformatf("v%0d_data%0d", idx, beats), stream_if.m_tdata, word(ea));
                    check($sformatf("v%0d_last%0d", idx, beats), 256'(stream_if.m_tlast),
                          256'(beats == len - 1));
                    if (beats == len - 1)
                        check($sformatf("v%0d_final_word", idx), stream_if.m_tdata, word(v.last_addr));
                    beats++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held_d = stream_if.m_tdata;
                    held_l = stream_if.m_tlast;
                end
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check($sformatf("v%0d_beats", idx), 256'(beats), 256'(len));
        check($sformatf("v%0d_reads", idx), 256'(enbs), 256'(len));
        check($sformatf("v%0d_early_done", idx), 256'(dones), 256'(0));
        check($sformatf("v%0d_done", idx), 256'(done), 256'(1));
        check($sformatf("v%0d_busy_end", idx), 256'(busy), 256'(0));
        check($sformatf("v%0d_tvalid_end", idx), 256'(stream_if.m_tvalid), 256'(0));
        step();
        check($sformatf("v%0d_done_pulse", idx), 256'(done), 256'(0));
        check($sformatf("v%0d_enb_idle", idx), 256'(enb), 256'(0));
    endtask

    initial begin
        vec_t vecs[7];
        cyc_t tm[10];
        vec_t post;
        int n;
        int cyc;
        bit bad;

        vecs[0] = '{15'h0010, 16'd4,   0, -1, -1, 15'h0013};
        vecs[1] = '{15'h7FFE, 16'd4,   0, -1, -1, 15'h0001};
        vecs[2] = '{15'h0200, 16'd20,  2,  8, -1, 15'h0213};
        vecs[3] = '{15'h1234, 16'd100, 1, -1, -1, 15'h1297};
        vecs[4] = '{15'h7FF0, 16'd1,   0, -1, -1, 15'h7FF0};
        vecs[5] = '{15'h7FC0, 16'd128, 1, -1, -1, 15'h003F};
        vecs[6] = '{15'h0300, 16'd6,   0, -1,  2, 15'h0305};

        tm[0] = '{1'b0, 15'h000, 1'b0, 1'b0, 15'h000, 1'b1, 1'b0};
        tm[1] = '{1'b1, 15'h010, 1'b0, 1'b0, 15'h000, 1'b1, 1'b0};
        tm[2] = '{1'b1, 15'h011, 1'b0, 1'b0, 15'h000, 1'b1, 1'b0};
        tm[3] = '{1'b1, 15'h012, 1'b0, 1'b0, 15'h000, 1'b1, 1'b0};
        tm[4] = '{1'b1, 15'h013, 1'b1, 1'b0, 15'h010, 1'b1, 1'b0};
        tm[5] = '{1'b0, 15'h000, 1'b1, 1'b0, 15'h011, 1'b1, 1'b0};
        tm[6] = '{1'b0, 15'h000, 1'b1, 1'b0, 15'h012, 1'b1, 1'b0};
        tm[7] = '{1'b0, 15'h000, 1'b1, 1'b1, 15'h013, 1'b1, 1'b0};
        tm[8] = '{1'b0, 15'h000, 1'b0, 1'b0, 15'h000, 1'b0, 1'b1};
        tm[9] = '{1'b0, 15'h000, 1'b0, 1'b0, 15'h000, 1'b0, 1'b0};

        stream_if.m_tready = 1'b0;
        step();
        step();
        check("rst_enb",    256'(enb),                256'(0));
        check("rst_addrb",  256'(addrb),              256'(0));
        check("rst_tvalid", 256'(stream_if.m_tvalid), 256'(0));
        check("rst_tlast",  256'(stream_if.m_tlast),  256'(0));
        check("rst_tdata",  stream_if.m_tdata,        256'(0));
        check("rst_busy",   256'(busy),               256'(0));
        check("rst_done",   256'(done),               256'(0));
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Cycle-exact basic read: edge T samples start.
        stream_if.m_tready = 1'b1;
        start = 1'b1; start_addr = 15'h0010; rd_len = 16'd4;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tm%0d_enb", k),    256'(enb),                256'(tm[k].enb));
            check($sformatf("tm%0d_tvalid", k), 256'(stream_if.m_tvalid), 256'(tm[k].tvalid));
            check($sformatf("tm%0d_tlast", k),  256'(stream_if.m_tlast),  256'(tm[k].tlast));
            check($sformatf("tm%0d_busy", k),   256'(busy),               256'(tm[k].busy));
            check($sformatf("tm%0d_done", k),   256'(done),               256'(tm[k].done));
            if (tm[k].enb)
                check($sformatf("tm%0d_addrb", k), 256'(addrb), 256'(tm[k].addrb));
            if (tm[k].tvalid)
                check($sformatf("tm%0d_tdata", k), stream_if.m_tdata, word(tm[k].daddr));
            step();
        end

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i], i);
            step();
        end

        // Zero-length command: done next cycle, never busy, no BRAM access.
        start = 1'b1; start_addr = 15'h0123; rd_len = 16'd0;
        step();
        start = 1'b0;
        check("zl_done", 256'(done), 256'(1));
        check("zl_busy", 256'(busy), 256'(0));
        check("zl_enb",  256'(enb),  256'(0));
        step();
        check("zl_done_pulse", 256'(done), 256'(0));
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (enb || busy) bad = 1'b1;
            step();
        end
        check("zl_quiet", 256'(bad), 256'(0));

        // Abort after the fifth issued read.
        stream_if.m_tready = 1'b1;
        start = 1'b1; start_addr = 15'h0500; rd_len = 16'd16;
        step();
        start = 1'b0;
        n = 0;
        cyc = 0;
        while (cyc < 50) begin
            if (enb) n++;
            if (n == 5) break;
            step();
            cyc++;
        end
        check("ab_reads_before", 256'(n), 256'(5));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_tvalid", 256'(stream_if.m_tvalid), 256'(0));
        check("ab_enb",    256'(enb),                256'(0));
        check("ab_busy",   256'(busy),               256'(0));
        check("ab_done",   256'(done),               256'(0));
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done || stream_if.m_tvalid || enb || busy) bad = 1'b1;
        end
        check("ab_quiet", 256'(bad), 256'(0));
        post = '{15'h0100, 16'd2, 0, -1, -1, 15'h0101};
        run_xfer(post, 10);
        step();

        // Asynchronous reset in the middle of a transfer.
        stream_if.m_tready = 1'b0;
        start = 1'b1; start_addr = 15'h0020; rd_len = 16'd10;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("mr_pre_tvalid", 256'(stream_if.m_tvalid), 256'(1));
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mr_enb",    256'(enb),                256'(0));
        check("mr_addrb",  256'(addrb),              256'(0));
        check("mr_tvalid", 256'(stream_if.m_tvalid), 256'(0));
        check("mr_tlast",  256'(stream_if.m_tlast),  256'(0));
        check("mr_tdata",  stream_if.m_tdata,        256'(0));
        check("mr_busy",   256'(busy),               256'(0));
        check("mr_done",   256'(done),               256'(0));
        step();
        step();
        @(negedge clk);
        rstn = 1'b1;
        step();
        post = '{15'h0040, 16'd3, 0, -1, -1, 15'h0042};
        run_xfer(post, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
